ex_muldiv_seq: RTL

Multi-cycle multiply/divide sequencer for the execute stage. It accepts one operation from ID through the `v_i`/`stall_o` handshake and runs an iterative shift-add multiply or restoring divide, one bit per cycle. It holds ID stalled while the operation runs. It then presents a single-cycle register-file writeback on the same `wb_o`/`rd_num_o`/`rd_data_o` bundle as the single-cycle ALU path.

---
 rtl/ex_muldiv_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative multiply/divide sequencer for the execute stage.
// One bit per cycle: shift-add multiply (MUL/MULHU) and restoring divide
// (DIVU/REMU). ID is stalled while RUN is active. The result is handed back
// as a single-cycle register-file writeback.
// Optional feature macro: MULDIV_DIV_EN compiles in the divider datapath.
// Without it, op 10/11 skips RUN, and its DONE cycle carries no writeback
// and a zero result.
module ex_muldiv_seq #(
  parameter int WORD = 32,
  parameter int W_RD = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  output logic            stall_o,
  input  logic [1:0]      op_i,
  input  logic [WORD-1:0] dest_i,
  input  logic [WORD-1:0] src_i,
  input  logic            wb_i,
  input  logic [W_RD-1:0] rd_num_i,
  output logic            wb_o,
  output logic [W_RD-1:0] rd_num_o,
  output logic [WORD-1:0] rd_data_o,
  output logic            busy_o
);

  localparam int CW = $clog2(WORD);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [1:0]        op_q;
  logic              wb_q;
  logic [W_RD-1:0]   rd_q;
  logic [WORD-1:0]   dest_q;
  logic [2*WORD-1:0] prod_q, prod_nx;
  logic [WORD:0]     psum;
  logic [WORD-1:0]   res;
  logic              accept;

  assign stall_o = (state == S_RUN);
  assign busy_o  = (state == S_RUN);
  assign accept  = v_i & ~stall_o;

  // Shift-add step: add the multiplicand into the upper half when the
  // multiplier LSB is set, keeping the carry, then shift the product right.
  always_comb begin
    psum    = {1'b0, prod_q[2*WORD-1:WORD]} + {1'b0, dest_q};
    prod_nx = prod_q[0] ? {psum, prod_q[WORD-1:1]} : {1'b0, prod_q[2*WORD-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WORD-1:0] rem_q, rem_nx, quo_q, quo_nx, dvs_q;
  logic [WORD:0]   rem_sh, rem_dif;

  // Restoring step: shift {rem, quo} left, trial-subtract the divisor and
  // keep the difference (setting the quotient bit) only when it is >= 0.
  // The remainder stays below the divisor, so WORD bits hold it.
  always_comb begin
    rem_sh  = {rem_q, quo_q[WORD-1]};
    rem_dif = rem_sh - {1'b0, dvs_q};
    rem_nx  = rem_dif[WORD] ? rem_sh[WORD-1:0] : rem_dif[WORD-1:0];
    quo_nx  = {quo_q[WORD-2:0], ~rem_dif[WORD]};
  end

  // Divider state: loaded on accept, stepped in RUN, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (accept) begin
      rem_q <= '0;
      quo_q <= dest_i;
      dvs_q <= src_i;
    end else if (state == S_RUN) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end
`endif

  // Result select from the final-iteration values. Divide by zero is
  // forced explicitly, so the result does not depend on the iteration.
  always_comb begin
    res = '0;
    case (op_q)
      2'b00: res = prod_nx[WORD-1:0];
      2'b01: res = prod_nx[2*WORD-1:WORD];
`ifdef MULDIV_DIV_EN
      2'b10: res = (dvs_q == '0) ? '1 : quo_nx;
      2'b11: res = (dvs_q == '0) ? dest_q : rem_nx;
`endif
      default: res = '0;
    endcase
  end

  // Control FSM, operand latches, multiply state and registered writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      wb_q      <= 1'b0;
      rd_q      <= '0;
      dest_q    <= '0;
      prod_q    <= '0;
      wb_o      <= 1'b0;
      rd_num_o  <= '0;
      rd_data_o <= '0;
    end else begin
      wb_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q   <= op_i;
            wb_q   <= wb_i;
            rd_q   <= rd_num_i;
            dest_q <= dest_i;
            prod_q <= {{WORD{1'b0}}, src_i};
            cnt    <= CW'(WORD - 1);
`ifdef MULDIV_DIV_EN
            state  <= S_RUN;
`else
            // No divider: a divide op goes straight to an empty DONE.
            if (op_i[1]) begin
              state     <= S_DONE;
              rd_num_o  <= rd_num_i;
              rd_data_o <= '0;
            end else begin
              state <= S_RUN;
            end
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          prod_q <= prod_nx;
          cnt    <= cnt - CW'(1);
          if (cnt == '0) begin
            state     <= S_DONE;
            wb_o      <= wb_q;
            rd_num_o  <= rd_q;
            rd_data_o <= res;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
